fixed_sqrt_iter: RTL

Iterative, non-restoring-free digit-by-digit square root for signed fixed-point values in D.Q format. It produces one result bit per clock. It sits directly downstream of the dot-product stage and consumes `r`/`output_valid` from a `dot(v, v)` computation to yield vector length. The ray-normalisation path then divides by that length. The result uses the same D.Q format as the input. The block is fixed-latency and accepts one operand per computation.

---
 rtl/fixed_pkg.sv | 27 ++
 rtl/fixed_sqrt_step.sv | 36 +++
 rtl/fixed_sqrt_iter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// ---------------------------------------------------------------------------
// fixed_pkg
// Shared definitions for the fixed-point arithmetic blocks of the ray
// pipeline.
//   DEFAULT_D / DEFAULT_Q : default D.Q split (integer bits incl. sign,
//                           fractional bits)
//   sqrt_latency(d, q)    : edges from operand accept to output_valid of
//                           fixed_sqrt_iter, for scheduling logic downstream
//   sqrt_state_t          : IDLE / RUN / DONE encoding of the sqrt sequencer
// ---------------------------------------------------------------------------
package fixed_pkg;

  localparam int DEFAULT_D = 8;
  localparam int DEFAULT_Q = 24;

  // One root bit per RUN cycle, plus the DONE cycle that registers the result.
  function automatic int sqrt_latency(input int d, input int q);
    return (d + 2 * q) / 2 + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

endpackage

// File: rtl/fixed_sqrt_step.sv
// ---------------------------------------------------------------------------
// fixed_sqrt_step
// One digit-by-digit square-root iteration, purely combinational.
//   W         : root width; the remainder is W+2 bits
//   rem       in  W+2 : current partial remainder
//   root      in  W   : current partial root
//   bits      in  2   : next radicand bit pair, MSB pair first
//   rem_next  out W+2 : updated remainder
//   root_next out W   : updated root (one more bit appended)
// ---------------------------------------------------------------------------
module fixed_sqrt_step #(
  parameter int W = 28
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   bits,
  output logic [W+1:0] rem_next,
  output logic [W-1:0] root_next
);

  // Work two bits wider than the remainder so the shifted remainder and the
  // trial value never overflow; the results are narrowed back afterwards.
  logic [W+3:0] rem_shift;
  logic [W+3:0] trial;
  logic         take;

  assign rem_shift = {rem, bits};
  assign trial     = {2'b00, root, 2'b01};
  assign take      = (rem_shift >= trial);

  assign rem_next  = take ? (W+2)'(rem_shift - trial) : (W+2)'(rem_shift);
  // The root never exceeds W bits after W iterations, so the dropped MSB is
  // always zero.
  assign root_next = W'({root, take});

endmodule

// File: rtl/fixed_sqrt_iter.sv
// ---------------------------------------------------------------------------
// fixed_sqrt_iter
// Iterative square root of a signed D.Q operand, one root bit per clock.
// Result is floor(sqrt(a)) in the same D.Q format; negative operands give
// r = 0 with err = 1 after the same latency.
//   clk          in  1   : clock, rising edge
//   rst          in  1   : asynchronous reset, active low
//   new_data     in  1   : operand strobe, sampled only while in_ready = 1
//   in_ready     out 1   : block can accept an operand (IDLE or DONE)
//   a            in  D+Q : signed D.Q operand
//   output_valid out 1   : one-cycle pulse when r / err are updated
//   busy         out 1   : iterating (RUN), D/2+Q cycles per operand
//   r            out D+Q : floor(sqrt(a)), D.Q, held until the next result
//   err          out 1   : the operand of the current r was negative
// ---------------------------------------------------------------------------
module fixed_sqrt_iter
  import fixed_pkg::*;
#(
  parameter int D = DEFAULT_D,
  parameter int Q = DEFAULT_Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_data,
  output logic         in_ready,
  input  logic [D+Q-1:0] a,
  output logic         output_valid,
  output logic         busy,
  output logic [D+Q-1:0] r,
  output logic         err
);

  localparam int N      = D + 2 * Q;         // radicand width
  localparam int ROOT_W = N / 2;             // root width / iteration count
  localparam int REM_W  = ROOT_W + 2;
  localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ROOT_W - 1);

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  sqrt_state_t state_reg, state_next;
  logic        load;    // capture a new operand this edge
  logic        step;    // perform one iteration this edge
  logic        finish;  // publish root/err this edge

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (new_data) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // new_data is deliberately ignored here; in_ready is low.
        step = 1'b1;
        if (cnt_reg == LAST_ITER) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Accepting here gives back-to-back operation with no bubble.
        finish = 1'b1;
        if (new_data) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready = (state_reg == IDLE) || (state_reg == DONE);
  assign busy     = (state_reg == RUN);

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [N-1:0]      rad_reg;      // radicand, consumed two bits per step
  logic [REM_W-1:0]  rem_reg;
  logic [ROOT_W-1:0] root_reg;
  logic              err_pend_reg; // err of the operand in flight
  logic [REM_W-1:0]  rem_next;
  logic [ROOT_W-1:0] root_next;
  logic [N-1:0]      rad_load;
  logic              a_neg;

  logic              valid_reg;
  logic [D+Q-1:0]    r_reg;
  logic              err_reg;

  assign a_neg    = a[D+Q-1];
  // Appending Q zero bits turns sqrt of a D.Q value into a D.Q root.
  // A negative operand is replaced by zero so the result is simply 0.
  assign rad_load = a_neg ? '0 : {a, {Q{1'b0}}};

  fixed_sqrt_step #(
    .W (ROOT_W)
  ) u_step (
    .rem       (rem_reg),
    .root      (root_reg),
    .bits      (rad_reg[N-1:N-2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad_reg      <= '0;
      rem_reg      <= '0;
      root_reg     <= '0;
      cnt_reg      <= '0;
      err_pend_reg <= 1'b0;
      valid_reg    <= 1'b0;
      r_reg        <= '0;
      err_reg      <= 1'b0;
    end else begin
      valid_reg <= finish;

      // Uses the completed root of the previous operand, even when a new
      // operand is loaded on the same edge.
      if (finish) begin
        r_reg   <= {{(D + Q - ROOT_W){1'b0}}, root_reg};
        err_reg <= err_pend_reg;
      end

      if (load) begin
        rad_reg      <= rad_load;
        rem_reg      <= '0;
        root_reg     <= '0;
        cnt_reg      <= '0;
        err_pend_reg <= a_neg;
      end else if (step) begin
        rad_reg  <= {rad_reg[N-3:0], 2'b00};
        rem_reg  <= rem_next;
        root_reg <= root_next;
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

  assign output_valid = valid_reg;
  assign r            = r_reg;
  assign err          = err_reg;

endmodule
